// File: rtl/sample_phase_sequencer_pkg.sv
// Shared constants for the sample phase sequencer: channel defaults,
// counter widths and the FSM state encoding.
package sample_phase_sequencer_pkg;

    localparam int NUM_CH_DEF = 8;
    localparam int CH_W_DEF   = 3;

    localparam int DIV_W   = 12;
    localparam int P1C_W   = 4;
    localparam int P2C_W   = 10;
    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] WAIT_CH = 2'd1;
    localparam logic [STATE_W-1:0] P1      = 2'd2;
    localparam logic [STATE_W-1:0] P2      = 2'd3;

endpackage

// File: rtl/sample_phase_sequencer_next_channel_finder.sv
// Round-robin channel picker: lowest active index above cur_ch, otherwise the
// lowest active index overall (wrap).
module sample_phase_sequencer_next_channel_finder #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 3
) (
    input  logic [NUM_CH-1:0] active_mask,
    input  logic [CH_W-1:0]   cur_ch,
    output logic [CH_W-1:0]   next_ch,
    output logic              wrap,
    output logic              any_active
);

    logic [CH_W-1:0] lowest;
    logic [CH_W-1:0] above;
    logic            found;

    // Scanning downwards leaves the lowest qualifying index in each result.
    always_comb begin
        lowest = '0;
        above  = '0;
        found  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (active_mask[i]) begin
                lowest = CH_W'(i);
                if (i > int'(cur_ch)) begin
                    above = CH_W'(i);
                    found = 1'b1;
                end
            end
        end
    end

    assign any_active = |active_mask;
    assign wrap       = ~found;
    assign next_ch    = found ? above : lowest;

endmodule

// File: rtl/sample_phase_sequencer.sv
// Per-channel AFE/ADC sampling sequencer: PHASE1 window, PHASE2 window and a
// conversion-start strobe for each active channel in round-robin order.
module sample_phase_sequencer
    import sample_phase_sequencer_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = CH_W_DEF
) (
    input  logic              HF_CLK,
    input  logic              NRST,
    input  logic              ENSAMP_sync,
    input  logic [11:0]       PHASE1DIV1,
    input  logic [3:0]        PHASE1COUNT,
    input  logic [9:0]        PHASE2COUNT,
    input  logic [NUM_CH-1:0] CHEN,
    input  logic [NUM_CH-1:0] AFERSTCH_sync,
    output logic              PHASE1,
    output logic              PHASE2,
    output logic [CH_W-1:0]   CH_SEL,
    output logic              CONV_START,
    output logic              FRAME_DONE,
    output logic              BUSY
);

    logic [STATE_W-1:0] state;
    logic [DIV_W-1:0]   div_q;
    logic [P1C_W-1:0]   p1c_q;
    logic [P2C_W-1:0]   p2c_q;
    logic [DIV_W-1:0]   div_cnt;
    logic [P1C_W-1:0]   tick_cnt;
    logic [P2C_W-1:0]   p2_cnt;

    logic [NUM_CH-1:0]  active_mask;
    logic [CH_W-1:0]    finder_cur;
    logic [CH_W-1:0]    next_ch;
    logic               wrap;
    logic               any_active;
    logic               in_slot;
    logic               p1_last;
    logic               p2_last;
    logic               start_slot;
    logic               conv_next;

    assign active_mask = CHEN & ~AFERSTCH_sync;
    assign in_slot     = (state == P1) || (state == P2);
    // Outside a slot, searching above the top index yields the lowest active channel.
    assign finder_cur  = in_slot ? CH_SEL : CH_W'(NUM_CH - 1);

    sample_phase_sequencer_next_channel_finder #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_finder (
        .active_mask (active_mask),
        .cur_ch      (finder_cur),
        .next_ch     (next_ch),
        .wrap        (wrap),
        .any_active  (any_active)
    );

    assign p1_last    = (state == P1) && (div_cnt == div_q) && (tick_cnt == p1c_q);
    assign p2_last    = (state == P2) && (p2_cnt == p2c_q);
    assign start_slot = any_active && ((state == IDLE) || (state == WAIT_CH) || p2_last);
    // The strobe is registered, so it is raised on the edge entering the last P2 cycle.
    assign conv_next  = (p1_last && (p2c_q == '0)) ||
                        ((state == P2) && !p2_last && ((p2_cnt + P2C_W'(1)) == p2c_q));

    always_ff @(posedge HF_CLK or negedge NRST) begin
        if (!NRST) begin
            state      <= IDLE;
            PHASE1     <= 1'b0;
            PHASE2     <= 1'b0;
            CH_SEL     <= '0;
            CONV_START <= 1'b0;
            FRAME_DONE <= 1'b0;
            BUSY       <= 1'b0;
            div_q      <= '0;
            p1c_q      <= '0;
            p2c_q      <= '0;
            div_cnt    <= '0;
            tick_cnt   <= '0;
            p2_cnt     <= '0;
        end else if (!ENSAMP_sync) begin
            state      <= IDLE;
            PHASE1     <= 1'b0;
            PHASE2     <= 1'b0;
            CH_SEL     <= '0;
            CONV_START <= 1'b0;
            FRAME_DONE <= 1'b0;
            BUSY       <= 1'b0;
        end else if (start_slot) begin
            state      <= P1;
            CH_SEL     <= next_ch;
            PHASE1     <= 1'b1;
            PHASE2     <= 1'b0;
            CONV_START <= 1'b0;
            FRAME_DONE <= 1'b0;
            BUSY       <= 1'b1;
            div_q      <= PHASE1DIV1;
            p1c_q      <= PHASE1COUNT;
            p2c_q      <= PHASE2COUNT;
            div_cnt    <= '0;
            tick_cnt   <= '0;
        end else begin
            CONV_START <= conv_next;
            FRAME_DONE <= conv_next & wrap;
            BUSY       <= 1'b1;
            case (state)
                P1: begin
                    if (div_cnt == div_q) begin
                        div_cnt <= '0;
                        if (tick_cnt == p1c_q) begin
                            state  <= P2;
                            PHASE1 <= 1'b0;
                            PHASE2 <= 1'b1;
                            p2_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + P1C_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                P2: begin
                    if (p2_last) begin
                        // Slot finished but nothing is active any more.
                        state  <= WAIT_CH;
                        PHASE2 <= 1'b0;
                        CH_SEL <= '0;
                    end else begin
                        p2_cnt <= p2_cnt + P2C_W'(1);
                    end
                end
                default: begin
                    state  <= WAIT_CH;
                    PHASE1 <= 1'b0;
                    PHASE2 <= 1'b0;
                    CH_SEL <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_phase_sequencer.sv
// Self-checking bench for sample_phase_sequencer: directed scenarios plus
// random traffic, each cycle compared with a slot-duration reference model.
module tb_sample_phase_sequencer;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_P1   = 2;
    localparam int M_P2   = 3;

    logic        hf_clk = 1'b0;
    logic        nrst   = 1'b1;
    logic        ens    = 1'b0;
    logic [11:0] div    = '0;
    logic [3:0]  p1c    = '0;
    logic [9:0]  p2c    = '0;
    logic [7:0]  chen   = '0;
    logic [7:0]  afe    = '0;

    logic        phase1, phase2, conv, fd, busy;
    logic [2:0]  ch_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase and remaining cycles in that phase.
    int m_st = M_IDLE;
    int m_ch = 0;
    int m_rem = 0;
    int m_p2_len = 0;
    bit e_p1, e_p2, e_conv, e_fd, e_busy;

    sample_phase_sequencer dut (
        .HF_CLK        (hf_clk),
        .NRST          (nrst),
        .ENSAMP_sync   (ens),
        .PHASE1DIV1    (div),
        .PHASE1COUNT   (p1c),
        .PHASE2COUNT   (p2c),
        .CHEN          (chen),
        .AFERSTCH_sync (afe),
        .PHASE1        (phase1),
        .PHASE2        (phase2),
        .CH_SEL        (ch_sel),
        .CONV_START    (conv),
        .FRAME_DONE    (fd),
        .BUSY          (busy)
    );

    // ---------------- clock ----------------
    always #5 hf_clk = ~hf_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int lowest_of(logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int next_after(logic [7:0] m, int c);
        for (int i = c + 1; i < 8; i++) if (m[i]) return i;
        return lowest_of(m);
    endfunction

    function automatic bit none_after(logic [7:0] m, int c);
        for (int i = c + 1; i < 8; i++) if (m[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_ch = 0; m_rem = 0;
        e_p1 = 0; e_p2 = 0; e_conv = 0; e_fd = 0; e_busy = 0;
    endtask

    task automatic model_step();
        logic [7:0] m;
        m = chen & ~afe;
        e_conv = 0;
        e_fd   = 0;
        if (!ens) begin
            model_reset();
        end else if (m_st == M_IDLE || m_st == M_WAIT || (m_st == M_P2 && m_rem == 1)) begin
            if (m != 0) begin
                m_ch     = (m_st == M_P2) ? next_after(m, m_ch) : lowest_of(m);
                m_st     = M_P1;
                m_rem    = (int'(p1c) + 1) * (int'(div) + 1);
                m_p2_len = int'(p2c) + 1;
                e_p1 = 1; e_p2 = 0; e_busy = 1;
            end else begin
                m_st = M_WAIT; m_ch = 0;
                e_p1 = 0; e_p2 = 0; e_busy = 1;
            end
        end else if (m_st == M_P1) begin
            m_rem--;
            if (m_rem == 0) begin
                m_st = M_P2; m_rem = m_p2_len;
                e_p1 = 0; e_p2 = 1;
                if (m_rem == 1) begin
                    e_conv = 1; e_fd = none_after(m, m_ch);
                end
            end
        end else begin
            m_rem--;
            if (m_rem == 1) begin
                e_conv = 1; e_fd = none_after(m, m_ch);
            end
        end
    endtask

    function automatic logic [7:0] exp_vec();
        return {e_p1, e_p2, 3'(m_ch), e_conv, e_fd, e_busy};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {phase1, phase2, ch_sel, conv, fd, busy};
    endfunction

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge hf_clk);
        model_step();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 nrst = 1'b0;
        #1;
        n_checks++;
        if (obs_vec() !== 8'h00) begin
            n_fail++; $display("FAIL reset_async: got %b expected %b", obs_vec(), 8'h00);
        end
        @(posedge hf_clk); #1;
        n_checks++;
        if (obs_vec() !== 8'h00) begin
            n_fail++; $display("FAIL reset_held: got %b expected %b", obs_vec(), 8'h00);
        end
        nrst = 1'b1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_idle: got %b expected %b", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        int p1_cycles;
        p1_cycles = 0;
        chen = 8'h05; afe = 8'h00; div = 12'd1; p1c = 4'd2; p2c = 10'd3;
        ens = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL basic_lockstep c%0d: got %b expected %b", k, obs_vec(), exp_vec());
            end
            if (k <= 10 && phase1) p1_cycles++;
            if (k == 1) begin
                n_checks++;
                if ({phase1, phase2, ch_sel} !== 5'b10_000) begin
                    n_fail++; $display("FAIL basic_p1_rise: got %b expected %b", {phase1, phase2, ch_sel}, 5'b10_000);
                end
            end
            if (k == 10) begin
                n_checks++;
                if ({phase2, conv, fd, ch_sel} !== 6'b110_000) begin
                    n_fail++; $display("FAIL basic_conv_ch0: got %b expected %b", {phase2, conv, fd, ch_sel}, 6'b110_000);
                end
            end
            if (k == 11) begin
                n_checks++;
                if ({phase1, ch_sel} !== 4'b1_010) begin
                    n_fail++; $display("FAIL basic_ch2_start: got %b expected %b", {phase1, ch_sel}, 4'b1_010);
                end
            end
            if (k == 20) begin
                n_checks++;
                if ({phase2, conv, fd, ch_sel} !== 6'b111_010) begin
                    n_fail++; $display("FAIL basic_frame_done: got %b expected %b", {phase2, conv, fd, ch_sel}, 6'b111_010);
                end
            end
            if (k == 21) begin
                n_checks++;
                if ({phase1, conv, fd, ch_sel} !== 6'b100_000) begin
                    n_fail++; $display("FAIL basic_wrap_ch0: got %b expected %b", {phase1, conv, fd, ch_sel}, 6'b100_000);
                end
            end
        end
        n_checks++;
        if (p1_cycles != 6) begin
            n_fail++; $display("FAIL basic_p1_width: got %0d expected %0d", p1_cycles, 6);
        end
        ens = 1'b0;
        tick();
    endtask

    task automatic test_wait_ch();
        int n_conv, n_fd;
        n_conv = 0; n_fd = 0;
        chen = 8'h00; afe = 8'h00; div = 12'd0; p1c = 4'd1; p2c = 10'd2;
        ens = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (obs_vec() !== 8'b0000_0001) begin
                n_fail++; $display("FAIL wait_busy_only: got %b expected %b", obs_vec(), 8'b0000_0001);
            end
        end
        chen = 8'h80;
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL wait_lockstep c%0d: got %b expected %b", k, obs_vec(), exp_vec());
            end
            if (k == 1) begin
                n_checks++;
                if ({phase1, ch_sel} !== 4'b1_111) begin
                    n_fail++; $display("FAIL wait_wake_ch7: got %b expected %b", {phase1, ch_sel}, 4'b1_111);
                end
            end
            if (conv) n_conv++;
            if (fd) n_fd++;
        end
        n_checks++;
        if (n_conv != 3 || n_fd != 3) begin
            n_fail++; $display("FAIL wait_single_frames: got conv=%0d fd=%0d expected conv=3 fd=3", n_conv, n_fd);
        end
        ens = 1'b0;
        tick();
    endtask

    task automatic test_afe_mid();
        logic [2:0] exp_q[$];
        logic [2:0] got_q[$];
        exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd2, 3'd3, 3'd0};
        chen = 8'h0F; afe = 8'h00; div = 12'd0; p1c = 4'd1; p2c = 10'd1;
        ens = 1'b1;
        for (int k = 1; k <= 60 && got_q.size() < 8; k++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL afe_lockstep c%0d: got %b expected %b", k, obs_vec(), exp_vec());
            end
            if (conv) got_q.push_back(ch_sel);
            if (m_st == M_P1 && m_ch == 1 && afe == 8'h00) afe = 8'h02;
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL afe_conv_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL afe_order[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]);
                end
            end
        end
        afe = 8'h00; ens = 1'b0;
        tick();
    endtask

    task automatic test_drop_ens();
        bit saw_conv, reached;
        saw_conv = 0; reached = 0;
        chen = 8'h06; afe = 8'h00; div = 12'd0; p1c = 4'd0; p2c = 10'd3;
        ens = 1'b1;
        for (int k = 1; k <= 50 && !reached; k++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL drop_lockstep c%0d: got %b expected %b", k, obs_vec(), exp_vec());
            end
            if (conv) saw_conv = 1;
            if (m_st == M_P2 && m_rem == 2) reached = 1;
        end
        n_checks++;
        if (!reached) begin
            n_fail++; $display("FAIL drop_reach_p2: got timeout expected second-to-last P2 cycle");
        end
        ens = 1'b0;
        tick();
        n_checks++;
        if (obs_vec() !== 8'h00 || saw_conv) begin
            n_fail++; $display("FAIL drop_suppressed: got %b conv_seen=%0d expected 00000000 conv_seen=0", obs_vec(), saw_conv);
        end
        n_checks++;
        if (dut.state !== sample_phase_sequencer_pkg::IDLE) begin
            n_fail++; $display("FAIL drop_state_idle: got %0d expected %0d", dut.state, sample_phase_sequencer_pkg::IDLE);
        end
    endtask

    task automatic test_extremes();
        int width;
        bit done;
        chen = 8'h11; afe = 8'h00; div = 12'd0; p1c = 4'd0; p2c = 10'd0;
        ens = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL min_lockstep c%0d: got %b expected %b", k, obs_vec(), exp_vec());
            end
            n_checks++;
            if ({phase1, phase2, conv} !== ((k % 2 == 1) ? 3'b100 : 3'b011)) begin
                n_fail++; $display("FAIL min_alternate c%0d: got %b expected %b", k, {phase1, phase2, conv},
                                   (k % 2 == 1) ? 3'b100 : 3'b011);
            end
        end
        ens = 1'b0;
        tick();

        width = 0; done = 0;
        chen = 8'h01; div = 12'd4095; p1c = 4'd15; p2c = 10'd0;
        ens = 1'b1;
        for (int k = 1; k <= 70000 && !done; k++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL max_lockstep c%0d: got %b expected %b", k, obs_vec(), exp_vec());
            end
            if (phase1) width++;
            else if (width > 0) done = 1;
        end
        n_checks++;
        if (width != 65536 || !done) begin
            n_fail++; $display("FAIL max_p1_width: got %0d expected %0d", width, 65536);
        end
        ens = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit reached;
        reached = 0;
        chen = 8'h0C; afe = 8'h00; div = 12'd0; p1c = 4'd1; p2c = 10'd4;
        ens = 1'b1;
        for (int k = 1; k <= 50 && !reached; k++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rstmid_lockstep c%0d: got %b expected %b", k, obs_vec(), exp_vec());
            end
            if (m_st == M_P2 && m_rem == 3) reached = 1;
        end
        n_checks++;
        if (!reached || !phase2) begin
            n_fail++; $display("FAIL rstmid_reach_p2: got phase2=%0d expected 1", phase2);
        end
        #3 nrst = 1'b0;
        #1;
        n_checks++;
        if (obs_vec() !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_immediate: got %b expected %b", obs_vec(), 8'h00);
        end
        model_reset();
        @(posedge hf_clk); #1;
        nrst = 1'b1;
        tick();
        n_checks++;
        if ({phase1, ch_sel, busy} !== 5'b1_010_1) begin
            n_fail++; $display("FAIL rstmid_restart: got %b expected %b", {phase1, ch_sel, busy}, 5'b1_010_1);
        end
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL rstmid_lockstep_after: got %b expected %b", obs_vec(), exp_vec());
        end
        ens = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int r;
        chen = 8'($urandom_range(1, 255)); afe = 8'h00;
        div = 12'd1; p1c = 4'd1; p2c = 10'd2;
        ens = 1'b1;
        for (int k = 1; k <= 3000; k++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_lockstep c%0d: got %b expected %b", k, obs_vec(), exp_vec());
            end
            r = $urandom_range(0, 199);
            if (r < 4)       chen = 8'($urandom_range(0, 255));
            else if (r < 7)  afe  = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            else if (r < 11) begin
                div = 12'($urandom_range(0, 3));
                p1c = 4'($urandom_range(0, 3));
                p2c = 10'($urandom_range(0, 5));
            end else if (r == 199) ens = ~ens;
            else if (!ens && r < 60) ens = 1'b1;
        end
        ens = 1'b0;
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_wait_ch();
        test_afe_mid();
        test_drop_ens();
        test_extremes();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_phase_sequencer.md
Name: sample_phase_sequencer

Overview:
- Consumes the HF_CLK-domain control and configuration outputs of the CDC synchroniser and drives the per-channel AFE/ADC sampling timing.
- For each enabled channel in round-robin order, it generates a divided PHASE1 window, then a PHASE2 window, then a one-cycle conversion-start strobe.
- It sits between the synchroniser and the ADC/decimator front end.

Parameters:
- NUM_CH, 8, number of multiplexed channels (CHEN/AFERSTCH width).
- CH_W, 3, channel index width, equal to clog2(NUM_CH).

Ports:
- HF_CLK  in  1  sampling-domain clock
- NRST  in  1  reset, asynchronous, active-low
- ENSAMP_sync  in  1  sampling enable, already synchronised
- PHASE1DIV1  in  12  PHASE1 tick divider; a tick lasts PHASE1DIV1+1 cycles
- PHASE1COUNT  in  4  PHASE1 length in ticks, minus 1
- PHASE2COUNT  in  10  PHASE2 length in HF_CLK cycles, minus 1
- CHEN  in  NUM_CH  channel enable mask
- AFERSTCH_sync  in  NUM_CH  per-channel AFE reset; a set bit excludes that channel
- PHASE1  out  1  PHASE1 window active
- PHASE2  out  1  PHASE2 window active
- CH_SEL  out  CH_W  channel currently being sampled
- CONV_START  out  1  one-cycle pulse on the last PHASE2 cycle
- FRAME_DONE  out  1  one-cycle pulse with CONV_START of the last active channel in a frame
- BUSY  out  1  high whenever the sequencer is not in IDLE

Behaviour:
- All outputs are registered. On reset, every output is 0 and the state is IDLE.
- Active mask = CHEN & ~AFERSTCH_sync, evaluated at every slot boundary.
- States:
  - IDLE: wait for ENSAMP_sync.
  - P1: PHASE1 asserted.
  - P2: PHASE2 asserted.
  - WAIT_CH: enabled, but the active mask is 0.
- IDLE -> P1 when ENSAMP_sync=1 and the active mask is non-zero.
  - CH_SEL = lowest active channel.
  - PHASE1 goes high on the same edge (1-cycle latency from ENSAMP_sync sampled high).
- IDLE -> WAIT_CH when ENSAMP_sync=1 and the active mask is 0. All outputs stay 0 except BUSY=1.
- WAIT_CH -> P1 on the first cycle the active mask becomes non-zero.
- Configuration snapshot: PHASE1DIV1, PHASE1COUNT and PHASE2COUNT are latched on every entry to P1. Mid-slot changes take effect at the next slot only.
- P1 timing:
  - A 12-bit divider counts 0..DIV; on wrap, a 4-bit tick counter increments.
  - Exit to P2 after exactly (PHASE1COUNT+1)*(PHASE1DIV1+1) cycles of PHASE1=1.
- P2 timing:
  - A 10-bit counter runs 0..PHASE2COUNT, giving exactly PHASE2COUNT+1 cycles of PHASE2=1.
  - CONV_START=1 on the final P2 cycle.
- End of P2:
  - The next channel is the lowest active index strictly greater than CH_SEL; otherwise wrap to the lowest active index.
  - When wrapping, or when CH_SEL is the only active channel, FRAME_DONE=1 coincident with CONV_START.
  - Next state is P1 with no gap cycle. If the active mask is 0 at this boundary, go to WAIT_CH.
- PHASE1 and PHASE2 are never high simultaneously.
- Boundary cases:
  - With all-zero config, PHASE1 lasts 1 cycle and PHASE2 lasts 1 cycle, so the slot is 2 cycles.
  - With maximum config, PHASE1 lasts 16*4096 = 65536 cycles. Counters must not overflow.
- ENSAMP_sync=0 in any state: on the next edge go to IDLE and clear all outputs. An in-flight CONV_START on that edge is suppressed. There is no completion of a partial slot.
- An active channel that becomes inactive (via CHEN or AFERSTCH) mid-slot finishes its current slot and is then skipped.
- An asynchronous NRST low at any point returns immediately to the reset state.

Decomposition:
- Shared package contents:
  - state enum {IDLE, WAIT_CH, P1, P2}
  - NUM_CH and CH_W defaults
  - counter widths: DIV_W=12, P1C_W=4, P2C_W=10
- Sub-module next_channel_finder: purely combinational.
  - Inputs: active mask and current CH_SEL.
  - Outputs: next index, wrap flag, any_active.
- The top level contains the FSM, the counters and the output registers.

Test Plan:
- CHEN=8'h05, AFERSTCH=0, DIV=1, P1COUNT=2, P2COUNT=3, ENSAMP rises at cycle 0:
  - PHASE1 is high cycles 1-6, PHASE2 cycles 7-10, CONV_START at 10 with CH_SEL=0.
  - Channel 2 then runs cycles 11-20, with CONV_START and FRAME_DONE at 20.
  - CH_SEL returns to 0 at 21.
- CHEN=8'h00 with ENSAMP=1:
  - BUSY=1, all other outputs 0.
  - Set CHEN=8'h80 -> PHASE1 rises the next cycle with CH_SEL=7.
  - FRAME_DONE accompanies every CONV_START.
- Running with CHEN=8'h0F, set AFERSTCH_sync=8'h02 during channel 1's P1:
  - Channel 1 completes its slot; the sequence then becomes 0, 2, 3, 0, ...
- Drop ENSAMP on the final P2 cycle: CONV_START is never asserted, and all outputs are 0 and the state is IDLE on the next edge.
- Configuration extremes:
  - DIV=0, P1COUNT=0, P2COUNT=0 -> 2-cycle slots with alternating PHASE1/PHASE2 and no idle gap.
  - DIV=4095, P1COUNT=15 -> PHASE1 width of exactly 65536 cycles.
- Assert NRST low mid-P2: all outputs are 0 immediately. After release with ENSAMP=1, sequencing restarts at the lowest active channel.
